acq_sequencer: RTL

- Run controller for the scope acquisition-to-display loop.
- Sequences the capture engine through arm, pre-trigger fill, trigger wait and post-trigger fill, then hands the frame to the LCD renderer with a display_en/display_done handshake.
- Implements auto, normal and single trigger modes, the stop control, holdoff between frames and the auto-mode forced trigger.
- Sits on the 100 MHz system clock between reg_decode outputs, data_handler and LCD.

---
 rtl/acq_if.sv | 37 +++
 rtl/acq_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/acq_if.sv
// acq_if: handshake bundle between acq_sequencer and its neighbours
// (reg_decode controls, capture engine, trigger comparator, LCD renderer).
// The master modport is the sequencer side; the slave modport is the surroundings.
interface acq_if #(
  parameter int unsigned ADDR_W = 14
);
  logic [1:0]        trig_mode;
  logic              stop;
  logic              single_arm;
  logic              cap_start;
  logic              cap_pre_done;
  logic              trig_hit;
  logic [ADDR_W-1:0] trig_addr;
  logic              cap_force;
  logic              cap_done;
  logic [ADDR_W-1:0] trig_pos;
  logic              forced;
  logic              display_en;
  logic              display_done;
  logic [15:0]       frame_cnt;
  logic [2:0]        state;
  logic              err;

  modport master (
    input  trig_mode, stop, single_arm, cap_pre_done, trig_hit, trig_addr,
           cap_done, display_done,
    output cap_start, cap_force, trig_pos, forced, display_en, frame_cnt,
           state, err
  );

  modport slave (
    output trig_mode, stop, single_arm, cap_pre_done, trig_hit, trig_addr,
           cap_done, display_done,
    input  cap_start, cap_force, trig_pos, forced, display_en, frame_cnt,
           state, err
  );
endinterface

// File: rtl/acq_sequencer.sv
// acq_sequencer: run controller for the scope acquisition-to-display loop.
// Arm -> pre-fill -> trigger wait -> post-fill -> display -> holdoff, with
// auto/normal/single trigger modes, stop control and auto forced trigger.
// Optional build macro: ACQ_WATCHDOG_EN adds a PRE/POST timeout with a
// sticky err flag; without it err is tied low and PRE/POST wait forever.
module acq_sequencer #(
  parameter int unsigned ADDR_W       = 14,
  parameter int unsigned AUTO_TIMEOUT = 5000000,
  parameter int unsigned HOLDOFF      = 1000,
  parameter int unsigned WATCHDOG     = 20000000
) (
  input  logic  clk,
  input  logic  rst,
  acq_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_PRE     = 3'd2,
    S_WAIT    = 3'd3,
    S_POST    = 3'd4,
    S_DISPLAY = 3'd5,
    S_HOLDOFF = 3'd6,
    S_HALT    = 3'd7
  } state_t;

  localparam logic [1:0] MODE_AUTO   = 2'd0;
  localparam logic [1:0] MODE_SINGLE = 2'd2;

  // One shared counter serves auto timeout, holdoff and the watchdog.
  localparam int unsigned MAX_AH  = (AUTO_TIMEOUT > HOLDOFF) ? AUTO_TIMEOUT : HOLDOFF;
  localparam int unsigned MAX_CNT = (MAX_AH > WATCHDOG) ? MAX_AH : WATCHDOG;
  localparam int unsigned CNT_W   = (MAX_CNT < 2) ? 1 : $clog2(MAX_CNT);

  localparam logic [CNT_W-1:0] AUTO_LAST = CNT_W'(AUTO_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF - 1);
`ifdef ACQ_WATCHDOG_EN
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WATCHDOG - 1);
`endif

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_cap_start;
  logic              r_cap_force;
  logic [ADDR_W-1:0] r_trig_pos;
  logic              r_forced;
  logic              r_display_en;
  logic [15:0]       r_frame_cnt;
`ifdef ACQ_WATCHDOG_EN
  logic              r_err;
`endif

  logic w_auto;
  logic w_single;

  assign w_auto   = (bus.trig_mode == MODE_AUTO);
  assign w_single = (bus.trig_mode == MODE_SINGLE);

  // Sequencer FSM with registered strobes, latches and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_cap_start  <= 1'b0;
      r_cap_force  <= 1'b0;
      r_trig_pos   <= '0;
      r_forced     <= 1'b0;
      r_display_en <= 1'b0;
      r_frame_cnt  <= '0;
`ifdef ACQ_WATCHDOG_EN
      r_err        <= 1'b0;
`endif
    end else begin
      r_cap_start <= 1'b0;
      r_cap_force <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (bus.stop) begin
            r_state <= S_HALT;
          end else begin
            r_state     <= S_ARM;
            r_cap_start <= 1'b1;
          end
        end

        S_ARM: begin
          r_cnt      <= '0;
          r_forced   <= 1'b0;
          r_trig_pos <= '0;
          r_state    <= bus.stop ? S_HALT : S_PRE;
        end

        S_PRE: begin
          if (bus.stop) begin
            r_state <= S_HALT;
            r_cnt   <= '0;
          end else if (bus.cap_pre_done) begin
            r_state <= S_WAIT;
            r_cnt   <= '0;
          end
`ifdef ACQ_WATCHDOG_EN
          else if (r_cnt == WDOG_LAST) begin
            r_err       <= 1'b1;
            r_state     <= S_ARM;
            r_cap_start <= 1'b1;
            r_cnt       <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
`endif
        end

        S_WAIT: begin
          if (bus.stop) begin
            r_state <= S_HALT;
            r_cnt   <= '0;
          end else if (bus.trig_hit) begin
            r_trig_pos <= bus.trig_addr;
            r_forced   <= 1'b0;
            r_state    <= S_POST;
            r_cnt      <= '0;
          end else if (w_auto) begin
            if (r_cnt == AUTO_LAST) begin
              r_cap_force <= 1'b1;
              r_trig_pos  <= bus.trig_addr;
              r_forced    <= 1'b1;
              r_state     <= S_POST;
              r_cnt       <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end else begin
            r_cnt <= '0;
          end
        end

        S_POST: begin
          if (bus.stop) begin
            r_state <= S_HALT;
            r_cnt   <= '0;
          end else if (bus.cap_done) begin
            r_state <= S_DISPLAY;
            r_cnt   <= '0;
          end
`ifdef ACQ_WATCHDOG_EN
          else if (r_cnt == WDOG_LAST) begin
            r_err       <= 1'b1;
            r_state     <= S_ARM;
            r_cap_start <= 1'b1;
            r_cnt       <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
`endif
        end

        S_DISPLAY: begin
          r_cnt <= '0;
          if (bus.display_done) begin
            r_display_en <= 1'b0;
            r_frame_cnt  <= r_frame_cnt + 16'd1;
            if (w_single || bus.stop) begin
              r_state <= S_HALT;
            end else if (HOLDOFF != 0) begin
              r_state <= S_HOLDOFF;
            end else begin
              r_state     <= S_ARM;
              r_cap_start <= 1'b1;
            end
          end else begin
            r_display_en <= 1'b1;
          end
        end

        S_HOLDOFF: begin
          if (bus.stop) begin
            r_state <= S_HALT;
            r_cnt   <= '0;
          end else if (r_cnt == HOLD_LAST) begin
            r_state     <= S_ARM;
            r_cap_start <= 1'b1;
            r_cnt       <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_HALT: begin
          r_cnt        <= '0;
          r_display_en <= 1'b0;
          if (!bus.stop && (!w_single || bus.single_arm)) begin
            r_state     <= S_ARM;
            r_cap_start <= 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.cap_start  = r_cap_start;
  assign bus.cap_force  = r_cap_force;
  assign bus.trig_pos   = r_trig_pos;
  assign bus.forced     = r_forced;
  assign bus.display_en = r_display_en;
  assign bus.frame_cnt  = r_frame_cnt;
  assign bus.state      = r_state;
`ifdef ACQ_WATCHDOG_EN
  assign bus.err        = r_err;
`else
  assign bus.err        = 1'b0;
`endif

endmodule
